spi_slave: RTL

- SPI mode-0 responder (CPOL=0, CPHA=0), MSB first, 8-bit frames. It forms the device end of the bus that the CPU-side `spi` master drives.
- Runs entirely on the system clock. The SPI pins are oversampled through 2-flop synchronizers.
- Local logic exchanges bytes through a one-byte RX holding register and a one-byte TX buffer, each with simple flags.
- Used as the on-chip peripheral model and as the bus-side endpoint for board-level devices.

---
 rtl/spi_slave.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8-bit frames, with all pins oversampled on clk.
// Define SPI_SLAVE_OVERRUN_EN to add the sticky overrun flag and its ovr_clr input.
module spi_slave #(
    parameter logic [7:0] FILL = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       n_cs,
    output logic       miso,
    output logic [7:0] rx_data,
    output logic       rx_full,
    input  logic       rx_rd,
    input  logic [7:0] tx_data,
    input  logic       tx_we,
    output logic       tx_empty
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    input  logic       ovr_clr,
    output logic       overrun
`endif
);

    typedef enum logic {
        IDLE     = 1'b0,
        SELECTED = 1'b1
    } state_e;

    state_e      state_q, state_d;

    logic        sclk_meta_q, sclk_meta_d;
    logic        sclk_sync_q, sclk_sync_d;
    logic        sclk_prev_q, sclk_prev_d;
    logic        n_cs_meta_q, n_cs_meta_d;
    logic        n_cs_sync_q, n_cs_sync_d;
    logic        mosi_meta_q, mosi_meta_d;
    logic        mosi_sync_q, mosi_sync_d;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  tx_buf_q, tx_buf_d;
    logic        tx_empty_q, tx_empty_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_full_q, rx_full_d;
    logic        miso_q, miso_d;

    logic        sclk_rise;
    logic        sclk_fall;
    logic        load_tx;
    logic        byte_done;

`ifdef SPI_SLAVE_OVERRUN_EN
    logic        overrun_q, overrun_d;
`endif

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

    always_comb begin
        sclk_meta_d = sclk;
        sclk_sync_d = sclk_meta_q;
        sclk_prev_d = sclk_sync_q;
        n_cs_meta_d = n_cs;
        n_cs_sync_d = n_cs_meta_q;
        mosi_meta_d = mosi;
        mosi_sync_d = mosi_meta_q;
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_empty_d = tx_empty_q;
        rx_data_d  = rx_data_q;
        rx_full_d  = rx_full_q;
        miso_d     = miso_q;
        load_tx    = 1'b0;
        byte_done  = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (!n_cs_sync_q) begin
                    state_d = SELECTED;
                    load_tx = 1'b1;
                end
            end
            SELECTED: begin
                miso_d = tx_shift_q[7];
                if (n_cs_sync_q) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[6:0], mosi_sync_q};
                        byte_done  = (bit_cnt_q == 3'd7);
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                    end
                    // A fall with the counter at 0 only happens right after a byte boundary.
                    if (sclk_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            load_tx = 1'b1;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b1};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The load sees the buffer as it was before any write in the same cycle.
        if (load_tx) begin
            tx_shift_d = tx_empty_q ? FILL : tx_buf_q;
            tx_empty_d = 1'b1;
        end
        if (tx_we) begin
            tx_buf_d   = tx_data;
            tx_empty_d = 1'b0;
        end

        if (byte_done) begin
            rx_data_d = {rx_shift_q[6:0], mosi_sync_q};
            rx_full_d = 1'b1;
        end else if (rx_rd) begin
            rx_full_d = 1'b0;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    always_comb begin
        overrun_d = overrun_q;
        if (byte_done && rx_full_q && !rx_rd) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            n_cs_meta_q <= 1'b1;
            n_cs_sync_q <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= FILL;
            tx_buf_q    <= '0;
            tx_empty_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_full_q   <= 1'b0;
            miso_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            sclk_meta_q <= sclk_meta_d;
            sclk_sync_q <= sclk_sync_d;
            sclk_prev_q <= sclk_prev_d;
            n_cs_meta_q <= n_cs_meta_d;
            n_cs_sync_q <= n_cs_sync_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_empty_q  <= tx_empty_d;
            rx_data_q   <= rx_data_d;
            rx_full_q   <= rx_full_d;
            miso_q      <= miso_d;
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_full  = rx_full_q;
    assign tx_empty = tx_empty_q;

endmodule
